// File: rtl/stump_pkg.sv
// Shared encodings for the Stump control unit: states, opcodes, branch conditions, flag bits.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package stump_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH   = 2'b00,
        ST_EXECUTE = 2'b01,
        ST_MEMORY  = 2'b10,
        ST_HALT    = 2'b11
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADC  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_SBC  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_LDST = 3'b110;
    localparam logic [2:0] OP_BCC  = 3'b111;

    localparam logic [3:0] COND_AL = 4'h0;
    localparam logic [3:0] COND_NV = 4'h1;
    localparam logic [3:0] COND_HI = 4'h2;
    localparam logic [3:0] COND_LS = 4'h3;
    localparam logic [3:0] COND_CC = 4'h4;
    localparam logic [3:0] COND_CS = 4'h5;
    localparam logic [3:0] COND_NE = 4'h6;
    localparam logic [3:0] COND_EQ = 4'h7;
    localparam logic [3:0] COND_VC = 4'h8;
    localparam logic [3:0] COND_VS = 4'h9;
    localparam logic [3:0] COND_PL = 4'hA;
    localparam logic [3:0] COND_MI = 4'hB;
    localparam logic [3:0] COND_GE = 4'hC;
    localparam logic [3:0] COND_LT = 4'hD;
    localparam logic [3:0] COND_GT = 4'hE;
    localparam logic [3:0] COND_LE = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    localparam logic [2:0]  REG_PC  = 3'b111;
    // BAL with offset -1: a branch to itself, used as the halt idiom.
    localparam logic [15:0] HALT_IR = 16'hE0FF;

endpackage

// File: rtl/stump_if.sv
// Control bundle between the Stump sequencer and its datapath (ir/flags in, decode and strobes out).
// Latency: n/a (wires only).
// Backpressure: none; master = controller, slave = datapath. Optional macro STUMP_HALT_EN adds 'halted'.
interface stump_if;
    logic [15:0] ir;
    logic [3:0]  flags_in;
    logic        fetch;
    logic        execute;
    logic        memory;
    logic [2:0]  alu_func;
    logic        c_in;
    logic        opB_imm;
    logic        ext_op;
    logic        reg_write;
    logic [2:0]  dest;
    logic [2:0]  srcA;
    logic [2:0]  srcB;
    logic [1:0]  shift_op;
    logic        mem_ren;
    logic        mem_wen;
    logic [3:0]  cc;
`ifdef STUMP_HALT_EN
    logic        halted;

    modport master (
        input  ir, flags_in,
        output fetch, execute, memory, alu_func, c_in, opB_imm, ext_op,
               reg_write, dest, srcA, srcB, shift_op, mem_ren, mem_wen, cc, halted
    );
    modport slave (
        output ir, flags_in,
        input  fetch, execute, memory, alu_func, c_in, opB_imm, ext_op,
               reg_write, dest, srcA, srcB, shift_op, mem_ren, mem_wen, cc, halted
    );
`else
    modport master (
        input  ir, flags_in,
        output fetch, execute, memory, alu_func, c_in, opB_imm, ext_op,
               reg_write, dest, srcA, srcB, shift_op, mem_ren, mem_wen, cc
    );
    modport slave (
        output ir, flags_in,
        input  fetch, execute, memory, alu_func, c_in, opB_imm, ext_op,
               reg_write, dest, srcA, srcB, shift_op, mem_ren, mem_wen, cc
    );
`endif
endinterface

// File: rtl/stump_cond_eval.sv
// Branch condition evaluator: cond[3:0] against {N,Z,V,C} -> cond_true.
// Latency: combinational.
// Backpressure: none. Ports: cond (ir[11:8]), cc (condition codes), cond_true.
module stump_cond_eval
    import stump_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] cc,
    output logic       cond_true
);

    logic n, z, v, c;

    assign n = cc[FLAG_N];
    assign z = cc[FLAG_Z];
    assign v = cc[FLAG_V];
    assign c = cc[FLAG_C];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_AL: cond_true = 1'b1;
            COND_NV: cond_true = 1'b0;
            COND_HI: cond_true = !c && !z;
            COND_LS: cond_true = c || z;
            COND_CC: cond_true = !c;
            COND_CS: cond_true = c;
            COND_NE: cond_true = !z;
            COND_EQ: cond_true = z;
            COND_VC: cond_true = !v;
            COND_VS: cond_true = v;
            COND_PL: cond_true = !n;
            COND_MI: cond_true = n;
            COND_GE: cond_true = (n == v);
            COND_LT: cond_true = (n != v);
            COND_GT: cond_true = !z && (n == v);
            COND_LE: cond_true = z || (n != v);
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/stump_control.sv
// Stump sequencer: FETCH -> EXECUTE -> (MEMORY), ALU/regfile/memory control and the {N,Z,V,C} register.
// Latency: ALU and branch instructions 2 cycles, LD/ST 3 cycles; all outputs combinational from state/ir/cc.
// Backpressure: none. Ports: clk, rst_n (async active-low), bus (stump_if.master). Macro STUMP_HALT_EN adds HALT.
module stump_control
    import stump_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    stump_if.master  bus
);

    state_t     state_q, state_d;
    logic [3:0] cc_q, cc_d;

    logic [2:0] op;
    logic       typ;
    logic       s_bit;
    logic       cond_true;

    logic [2:0] alu_func;
    logic       opb_imm;
    logic       ext_op;
    logic       reg_write;
    logic [2:0] dest;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic       mem_ren;
    logic       mem_wen;

    assign op    = bus.ir[15:13];
    assign typ   = bus.ir[12];
    assign s_bit = bus.ir[11];

    stump_cond_eval u_cond_eval (
        .cond      (bus.ir[11:8]),
        .cc        (cc_q),
        .cond_true (cond_true)
    );

    always_comb begin
        state_d   = ST_FETCH;
        cc_d      = cc_q;
        alu_func  = OP_ADD;
        opb_imm   = 1'b0;
        ext_op    = 1'b0;
        reg_write = 1'b0;
        dest      = bus.ir[10:8];
        src_a     = bus.ir[7:5];
        src_b     = bus.ir[4:2];
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // PC <- PC+1 from the incrementer.
                reg_write = 1'b1;
                dest      = REG_PC;
                state_d   = ST_EXECUTE;
            end

            ST_EXECUTE: begin
                if (op <= OP_OR) begin
                    alu_func  = op;
                    opb_imm   = typ;
                    reg_write = 1'b1;
                    if (s_bit) begin
                        cc_d = bus.flags_in;
                    end
                    state_d = ST_FETCH;
                end else if (op == OP_LDST) begin
                    // Effective address only; result is consumed by the MEMORY cycle.
                    alu_func = OP_ADD;
                    opb_imm  = typ;
                    state_d  = ST_MEMORY;
                end else begin
                    // Bcc: PC <- PC + sign-extended 8-bit offset, written only if taken.
                    alu_func  = OP_ADD;
                    src_a     = REG_PC;
                    opb_imm   = 1'b1;
                    ext_op    = 1'b1;
                    dest      = REG_PC;
                    reg_write = cond_true;
                    state_d   = ST_FETCH;
`ifdef STUMP_HALT_EN
                    if (bus.ir == HALT_IR) begin
                        state_d = ST_HALT;
                    end
`endif
                end
            end

            ST_MEMORY: begin
                if (s_bit) begin
                    mem_ren   = 1'b1;
                    reg_write = 1'b1;
                end else begin
                    // Store data comes from the register named in the dest field.
                    mem_wen = 1'b1;
                    src_b   = bus.ir[10:8];
                end
                state_d = ST_FETCH;
            end

            default: begin
`ifdef STUMP_HALT_EN
                // Sticky until reset.
                state_d = ST_HALT;
`else
                state_d = ST_FETCH;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            cc_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
        end
    end

    assign bus.fetch    = (state_q == ST_FETCH);
    assign bus.execute  = (state_q == ST_EXECUTE);
    assign bus.memory   = (state_q == ST_MEMORY);
    assign bus.alu_func = alu_func;
    assign bus.c_in     = cc_q[FLAG_C];
    assign bus.opB_imm  = opb_imm;
    assign bus.ext_op   = ext_op;
    assign bus.dest     = dest;
    assign bus.srcA     = src_a;
    assign bus.srcB     = src_b;
    assign bus.shift_op = typ ? 2'b00 : bus.ir[1:0];
    assign bus.cc       = cc_q;

    // Strobes are held off while reset is asserted so an interrupted
    // instruction commits nothing once rst_n has fallen.
    assign bus.reg_write = reg_write & rst_n;
    assign bus.mem_ren   = mem_ren & rst_n;
    assign bus.mem_wen   = mem_wen & rst_n;

`ifdef STUMP_HALT_EN
    assign bus.halted = (state_q == ST_HALT);
`endif

endmodule

// File: doc/stump_control.md
Name: stump_control

Overview:
- Sequencer that drives the Stump ALU and datapath.
- Decodes the 16-bit instruction register and steps FETCH -> EXECUTE -> (MEMORY).
- Generates ALU function, carry-in, register-file and memory strobes.
- Holds the {N,Z,V,C} condition-code register; evaluates branch conditions against it.

Parameters:
- STATE_W, 2, width of the state encoding.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- ir  input  16  instruction register contents, valid from EXECUTE onward
- flags_in  input  4  ALU flags_out {N,Z,V,C}
- fetch  output  1  state == FETCH
- execute  output  1  state == EXECUTE
- memory  output  1  state == MEMORY
- alu_func  output  3  function code to the ALU
- c_in  output  1  ALU carry-in = cc[0]
- opB_imm  output  1  1 = immediate operand B, 0 = register
- ext_op  output  1  1 = sign-extend 8-bit branch offset, 0 = 5-bit immediate
- reg_write  output  1  register-file write enable this cycle
- dest  output  3  destination register
- srcA  output  3  source register A
- srcB  output  3  source register B
- shift_op  output  2  shifter control (ir[1:0] when type==0, else 00)
- mem_ren  output  1  memory read strobe
- mem_wen  output  1  memory write strobe
- cc  output  4  condition-code register {N,Z,V,C}

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = FETCH; cc = 0000.
  - All outputs are combinational from state/ir/cc; after reset fetch = 1, others 0.
  - Reset mid-instruction aborts it: no reg_write, no mem strobe after rst_n falls.
- Decode fields:
  - op = ir[15:13]; type = ir[12]; S = ir[11].
  - dest = ir[10:8]; srcA = ir[7:5]; srcB = ir[4:2].
- States, one cycle each:
  - FETCH: reg_write = 1, dest = 3'b111 (PC write from incrementer); next EXECUTE.
  - EXECUTE:
    - op 000-101 (ADD, ADC, SUB, SBC, AND, OR): alu_func = op; opB_imm = type; reg_write = 1; next FETCH.
    - op 110 (LD/ST): alu_func = ADD, address computed; reg_write = 0; next MEMORY.
    - op 111 (Bcc): alu_func = ADD; srcA = 3'b111; opB_imm = 1; ext_op = 1; dest = 3'b111; reg_write = cond_true; next FETCH.
  - MEMORY:
    - ir[11] = 1 (LD): mem_ren = 1, reg_write = 1 to dest.
    - ir[11] = 0 (ST): mem_wen = 1, srcB = ir[10:8] supplies store data, reg_write = 0.
    - Next FETCH.
- Condition-code update:
  - cc <= flags_in at end of EXECUTE only when op <= 101 and S = 1.
  - Never updated by LD/ST or Bcc.
  - C from a shift is already merged by the ALU.
- Branch conditions (ir[11:8]):
  - 0 AL, 1 NV, 2 HI (!C&!Z), 3 LS (C|Z), 4 CC (!C), 5 CS (C), 6 NE, 7 EQ.
  - 8 VC, 9 VS, A PL, B MI, C GE (N==V), D LT, E GT (!Z & N==V), F LE.
- Latency: ALU/branch instructions take 2 cycles; LD/ST take 3.
- Simultaneous events: ir changes during EXECUTE are not permitted (datapath holds ir from the FETCH write). The controller samples ir combinationally and adds no latch.
- Unused state encoding 2'b11: next state FETCH, all strobes 0.

Optional Feature:
- STUMP_HALT_EN defined:
  - EXECUTE of ir == 16'hE0FF (BAL to self) enters HALT (encoding 2'b11).
  - In HALT all strobes are 0 and halted = 1 (extra output port present only with the macro).
  - Only rst_n leaves HALT.
- STUMP_HALT_EN undefined:
  - 16'hE0FF executes as an ordinary branch (infinite loop).
  - 2'b11 behaves as the unused state above.

Decomposition:
- Package stump_pkg:
  - state encodings FETCH = 00, EXECUTE = 01, MEMORY = 10, HALT = 11;
  - opcode constants ADD..OR, LDST = 110, BCC = 111;
  - 4-bit condition-code constants;
  - flag bit indices N = 3, Z = 2, V = 1, C = 0.
- Sub-module stump_cond_eval: combinational (cond[3:0], cc[3:0]) -> cond_true. It is reused by the verification model.

Test Plan:
- Reset mid-MEMORY of an ST: assert rst_n = 0 during MEMORY -> mem_wen drops immediately, state FETCH, cc = 0000.
- ir = 16'h0A22 (ADD S = 1, dest 2), flags_in = 4'b0101:
  - sequence FETCH -> EXECUTE -> FETCH;
  - alu_func = 000, reg_write = 1, dest = 2;
  - cc = 0101 after EXECUTE.
- Same opcode with S = 0 (16'h0222), flags_in = 1111 -> cc unchanged.
- ir = 16'hC845 (LD):
  - 3-cycle sequence, mem_ren = 1 only in MEMORY;
  - reg_write in FETCH and MEMORY, not EXECUTE.
- ir = 16'hC045 (ST) -> mem_wen = 1 only in MEMORY; reg_write = 0 in EXECUTE and MEMORY.
- Bcc sweep: for all 16 cond codes x all 16 cc values, reg_write in EXECUTE equals the reference table. Spot checks:
  - cond 7 (EQ) with cc = 0100 -> 1;
  - cond C (GE) with cc = 1000 -> 0.
- STUMP_HALT_EN: ir = 16'hE0FF -> halted = 1 after EXECUTE and remains 1 for 10 cycles; rst_n pulse -> FETCH.
